json_feed_arb: RTL and testbench
================================

JSON_FEED_ARB -- requirements
Module: json_feed_arb

Interface
REQ-001 Parameter MAX_LEN, default 255, meaning: max characters forwarded per granted object (legal range 2..255).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  source 0 has a character at its head.
REQ-005 req0_char  input  8  source 0 head character (ASCII).
REQ-006 req0_ready  output  1  source 0 head consumed this cycle when valid&ready.
REQ-007 req1_valid / req1_char / req1_ready  same as REQ-004..006 for source 1.
REQ-008 out_valid  output  1  forwarded character valid toward parser.
REQ-009 out_char  output  8  forwarded character.
REQ-010 out_ready  input  1  parser accepts out_char this cycle.
REQ-011 owner  output  1  source currently granted; valid while busy=1.
REQ-012 busy  output  1  1 in state FWD.
REQ-013 obj_cnt0, obj_cnt1  output  8 each  completed objects per source, wrap at 255->0.
REQ-014 err_overrun  output  1  sticky: an object was aborted at MAX_LEN.

Function
REQ-015 States SHALL be IDLE and FWD; registers: state, owner, rr_ptr, in_str, len[7:0], obj_cnt0/1, err_overrun.
REQ-016 Transfer on a source SHALL mean reqX_valid & reqX_ready in the same cycle.
REQ-017 IDLE: reqX_ready SHALL be reqX_valid & (reqX_char != 8'h7B); such heads are discarded (not forwarded), both sources independently, same cycle.
REQ-018 IDLE: a head equal to 8'h7B ('{') SHALL NOT be consumed; it makes that source a candidate.
REQ-019 IDLE, one candidate: next cycle state=FWD, owner=that source.
REQ-020 IDLE, both candidates: owner=rr_ptr; the other source waits.
REQ-021 On grant, in_str and len SHALL clear to 0.
REQ-022 FWD: out_valid=req[owner]_valid, out_char=req[owner]_char, req[owner]_ready=out_ready, combinational; non-owner ready=0.
REQ-023 FWD: out_valid=0 in IDLE; out_char SHALL be 8'h00 when out_valid=0.
REQ-024 Latency: '{' at head in IDLE at cycle N is presented on out_char at cycle N+1 (zero-latency pass-through thereafter).
REQ-025 Each owner transfer SHALL increment len; a transferred 8'h22 SHALL toggle in_str.
REQ-026 Transferred 8'h7D ('}') with in_str=0 SHALL close: obj_cnt[owner]+=1, state->IDLE, rr_ptr<=~owner.
REQ-027 '}' with in_str=1 SHALL be forwarded as ordinary data.
REQ-028 Transfer that makes len==MAX_LEN and is not a closing '}': state->IDLE, err_overrun<=1, no count, rr_ptr<=~owner.
REQ-029 Closing '}' as the MAX_LEN-th character SHALL close normally (REQ-026), no error.
REQ-030 Owner valid=0 or out_ready=0 in FWD: no state change, hold all registers.
REQ-031 rr_ptr SHALL change only at object close or abort, never on single-candidate grant absence.

Reset
REQ-032 reset=1 at a rising edge SHALL force state=IDLE, owner=0, rr_ptr=0, in_str=0, len=0, obj_cnt0=0, obj_cnt1=0, err_overrun=0, regardless of current state (mid-object included).
REQ-033 During and after reset cycle, out_valid=0, out_char=8'h00, busy=0; ready outputs follow REQ-017 from IDLE.
REQ-034 An object interrupted by reset SHALL NOT be counted; next grant restarts from '{'.

Verification
REQ-035 Src0 streams "ab{\"k\":\"v\"}", out_ready=1 -> 'a','b' discarded, 9 chars forwarded starting 1 cycle after '{' at head, obj_cnt0=1, rr_ptr=1.
REQ-036 Both heads '{' after reset -> src0 granted first, src1 after src0's '}', then src0 again; obj_cnt0=2, obj_cnt1=1 after three objects.
REQ-037 Src1 sends {"a}b":"x"} -> inner '}' forwarded, object closes only at final '}', obj_cnt1=1.
REQ-038 MAX_LEN=8, src0 sends '{' plus 10 non-'}' chars -> abort after 8th transfer, err_overrun=1, obj_cnt0=0, busy=0; obj_cnt wraps 255->0 on 256th object.
REQ-039 out_ready toggling 0/1 mid-object -> no char lost or duplicated; reset asserted mid-object -> all outputs to reset values next cycle, count unchanged at 0.

Source files
------------

// File: rtl/json_feed_arb.sv
// json_feed_arb: round-robin arbiter that hands whole JSON objects from two
// character sources to a single parser, dropping inter-object junk.
module json_feed_arb #(
    parameter int MAX_LEN = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_char,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_char,
    output logic       req1_ready,
    output logic       out_valid,
    output logic [7:0] out_char,
    input  logic       out_ready,
    output logic       owner,
    output logic       busy,
    output logic [7:0] obj_cnt0,
    output logic [7:0] obj_cnt1,
    output logic       err_overrun
);
    localparam logic [7:0] MAX = 8'(MAX_LEN);
    typedef enum logic {IDLE, FWD} state_t;
    state_t state, state_nxt;
    logic rr_ptr, in_str, cand0, cand1, grant, grant_owner, own_valid, xfer, closing, at_max;
    logic [7:0] len, own_char;
    assign cand0 = req0_valid && req0_char == 8'h7B;
    assign cand1 = req1_valid && req1_char == 8'h7B;
    assign busy = state == FWD;
    assign own_valid = owner ? req1_valid : req0_valid;
    assign own_char = owner ? req1_char : req0_char;
    assign xfer = busy && own_valid && out_ready;
    assign closing = xfer && own_char == 8'h7D && !in_str;
    assign at_max = xfer && len + 8'd1 == MAX;
    assign grant = !busy && (cand0 || cand1);
    assign grant_owner = cand0 && cand1 ? rr_ptr : cand1;
    // The opening brace stays at the source head so it is the first forwarded char.
    always_comb begin
        state_nxt = state;
        if (grant)
            state_nxt = FWD;
        else if (closing || at_max)
            state_nxt = IDLE;
        out_valid = busy && own_valid;
        out_char = out_valid ? own_char : 8'h00;
        req0_ready = busy ? !owner && out_ready : req0_valid && !cand0;
        req1_ready = busy ? owner && out_ready : req1_valid && !cand1;
    end
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= 1'b0;
            rr_ptr <= 1'b0;
            in_str <= 1'b0;
            len <= 8'd0;
            obj_cnt0 <= 8'd0;
            obj_cnt1 <= 8'd0;
            err_overrun <= 1'b0;
        end else begin
            if (grant) begin
                owner <= grant_owner;
                in_str <= 1'b0;
                len <= 8'd0;
            end
            if (xfer) begin
                len <= len + 8'd1;
                if (own_char == 8'h22)
                    in_str <= !in_str;
            end
            if (closing) begin
                if (owner)
                    obj_cnt1 <= obj_cnt1 + 8'd1;
                else
                    obj_cnt0 <= obj_cnt0 + 8'd1;
                rr_ptr <= !owner;
            end else if (at_max) begin
                err_overrun <= 1'b1;
                rr_ptr <= !owner;
            end
        end
    end
endmodule

// File: tb/tb_json_feed_arb.sv
// tb_json_feed_arb: drives both sources from character queues and checks the
// forwarded stream against a per-source object extractor.
module tb_json_feed_arb;
    logic clk = 1'b0, reset = 1'b0, out_ready = 1'b0, sel8 = 1'b0;
    logic v [2];
    logic [7:0] c [2];
    logic ra0, ra1, ova, owa, bya, era, rb0, rb1, ovb, owb, byb, erb;
    logic [7:0] oca, c0a, c1a, ocb, c0b, c1b;
    logic rdy [2];
    logic ov, own, by, er;
    logic [7:0] oc;
    logic [7:0] cnt [2];
    int checks = 0, errors = 0, fwd_n = 0, cur_rem = 0;
    logic [7:0] src_q [2][$];
    logic [7:0] exp_f [2][$];
    int exp_len [2][$];
    int exp_cnt [2];
    int grants [$];
    bit exp_err, m_rr, m_busy, m_owner, exp_grant, exp_idle;

    always #5 clk = ~clk;

    json_feed_arb dut (
        .clk(clk), .reset(reset),
        .req0_valid(v[0]), .req0_char(c[0]), .req0_ready(ra0),
        .req1_valid(v[1]), .req1_char(c[1]), .req1_ready(ra1),
        .out_valid(ova), .out_char(oca), .out_ready(out_ready),
        .owner(owa), .busy(bya), .obj_cnt0(c0a), .obj_cnt1(c1a), .err_overrun(era)
    );
    json_feed_arb #(.MAX_LEN(8)) dut8 (
        .clk(clk), .reset(reset),
        .req0_valid(v[0]), .req0_char(c[0]), .req0_ready(rb0),
        .req1_valid(v[1]), .req1_char(c[1]), .req1_ready(rb1),
        .out_valid(ovb), .out_char(ocb), .out_ready(out_ready),
        .owner(owb), .busy(byb), .obj_cnt0(c0b), .obj_cnt1(c1b), .err_overrun(erb)
    );

    always_comb begin
        rdy[0] = sel8 ? rb0 : ra0;
        rdy[1] = sel8 ? rb1 : ra1;
        ov = sel8 ? ovb : ova;
        oc = sel8 ? ocb : oca;
        own = sel8 ? owb : owa;
        by = sel8 ? byb : bya;
        er = sel8 ? erb : era;
        cnt[0] = sel8 ? c0b : c0a;
        cnt[1] = sel8 ? c1b : c1a;
    end

    task automatic push_str(input int s, input string t);
        for (int i = 0; i < t.len(); i++) src_q[s].push_back(t[i]);
    endtask

    // Each source's forwarded text depends only on its own stream: skip junk,
    // take '{' up to the first '}' outside a string, or stop at the length cap.
    task automatic load();
        bit idle, str;
        int n, mx;
        logic [7:0] ch;
        mx = sel8 ? 8 : 255;
        for (int s = 0; s < 2; s++) begin
            idle = 1; str = 0; n = 0;
            exp_f[s].delete();
            exp_len[s].delete();
            for (int k = 0; k < src_q[s].size(); k++) begin
                ch = src_q[s][k];
                if (idle && ch != 8'h7B) continue;
                if (idle) begin idle = 0; str = 0; n = 0; end
                exp_f[s].push_back(ch);
                n++;
                if (ch == 8'h22) str = !str;
                if (ch == 8'h7D && !str) begin
                    exp_cnt[s]++; exp_len[s].push_back(n); idle = 1;
                end else if (n == mx) begin
                    exp_err = 1; exp_len[s].push_back(n); idle = 1;
                end
            end
        end
    endtask

    task automatic gen(input int s, input int nobj);
        string junk = "ab}\"x", body = "a\":}1";
        logic [7:0] ch;
        bit str;
        for (int k = 0; k < nobj; k++) begin
            for (int j = $urandom_range(0, 3); j > 0; j--) src_q[s].push_back(junk[$urandom_range(0, 4)]);
            src_q[s].push_back(8'h7B);
            str = 0;
            for (int j = $urandom_range(0, 12); j > 0; j--) begin
                ch = body[$urandom_range(0, 4)];
                if (ch == 8'h7D && !str) ch = "b";
                if (ch == 8'h22) str = !str;
                src_q[s].push_back(ch);
            end
            if (str) src_q[s].push_back(8'h22);
            src_q[s].push_back(8'h7D);
        end
    endtask

    task automatic run(input int budget, input bit rv, input bit rr, input bit need_done);
        bit done = 0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            bit cand [2];
            bit o;
            logic [7:0] e;
            @(negedge clk);
            if (exp_grant) begin
                checks++;
                if (by !== 1'b1 || own !== m_owner) begin
                    errors++;
                    $display("FAIL grant: busy=%b owner=%b, want busy=1 owner=%b", by, own, m_owner);
                end
                grants.push_back(int'(own));
                m_busy = 1; exp_grant = 0;
                cur_rem = exp_len[m_owner].size() > 0 ? exp_len[m_owner].pop_front() : -1;
            end
            if (exp_idle) begin
                checks++;
                if (by !== 1'b0) begin errors++; $display("FAIL release: busy=%b, want 0", by); end
                m_busy = 0; exp_idle = 0;
            end
            for (int s = 0; s < 2; s++) begin
                v[s] = src_q[s].size() > 0 && (!rv || $urandom_range(3) != 0);
                c[s] = src_q[s].size() > 0 ? src_q[s][0] : 8'h7B;
            end
            out_ready = !rr || $urandom_range(1) == 1;
            #1;
            if (!m_busy) begin
                for (int s = 0; s < 2; s++) begin
                    cand[s] = v[s] && c[s] == 8'h7B;
                    checks++;
                    if (rdy[s] !== (v[s] && !cand[s])) begin
                        errors++;
                        $display("FAIL idle_ready%0d: got %b, want %b", s, rdy[s], v[s] && !cand[s]);
                    end
                    if (v[s] && !cand[s]) void'(src_q[s].pop_front());
                end
                checks++;
                if (ov !== 1'b0 || oc !== 8'h00) begin
                    errors++; $display("FAIL idle_out: valid=%b char=%h, want 0/00", ov, oc);
                end
                if (cand[0] || cand[1]) begin
                    m_owner = cand[0] && cand[1] ? m_rr : cand[1];
                    exp_grant = 1;
                end
            end else begin
                o = m_owner;
                checks++;
                if (ov !== v[o] || oc !== (v[o] ? c[o] : 8'h00) || rdy[o] !== out_ready || rdy[~o] !== 1'b0) begin
                    errors++;
                    $display("FAIL fwd: valid=%b char=%h rdy_own=%b rdy_other=%b, want %b %h %b 0",
                             ov, oc, rdy[o], rdy[~o], v[o], v[o] ? c[o] : 8'h00, out_ready);
                end
                if (v[o] && out_ready) begin
                    e = exp_f[o].size() > 0 ? exp_f[o].pop_front() : 8'hxx;
                    checks++;
                    if (oc !== e) begin errors++; $display("FAIL stream%0d: got %h, want %h", o, oc, e); end
                    void'(src_q[o].pop_front());
                    fwd_n++;
                    if (--cur_rem == 0) begin exp_idle = 1; m_rr = !o; end
                end
            end
            done = src_q[0].size() == 0 && src_q[1].size() == 0 && !m_busy && !exp_grant && !exp_idle;
        end
        v[0] = 0; v[1] = 0;
        if (need_done) begin
            checks++;
            if (!done) begin errors++; $display("FAIL timeout: stream not drained in %0d cycles", budget); end
            checks++;
            if (cnt[0] !== 8'(exp_cnt[0]) || cnt[1] !== 8'(exp_cnt[1]) || er !== exp_err) begin
                errors++;
                $display("FAIL counts: cnt0=%0d cnt1=%0d err=%b, want %0d %0d %b",
                         cnt[0], cnt[1], er, 8'(exp_cnt[0]), 8'(exp_cnt[1]), exp_err);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; out_ready = 1;
        v[0] = 1; c[0] = "x"; v[1] = 1; c[1] = 8'h7B;
        @(negedge clk);
        #1;
        checks++;
        if (by !== 0 || ov !== 0 || oc !== 8'h00 || own !== 0 || cnt[0] !== 0 || cnt[1] !== 0 || er !== 0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b char=%h owner=%b cnt0=%0d cnt1=%0d err=%b, want all 0",
                     by, ov, oc, own, cnt[0], cnt[1], er);
        end
        checks++;
        if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin
            errors++; $display("FAIL reset_ready: rdy0=%b rdy1=%b, want 1 0", rdy[0], rdy[1]);
        end
        reset = 0; v[0] = 0; v[1] = 0;
        m_rr = 0; m_busy = 0; exp_grant = 0; exp_idle = 0; exp_err = 0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        grants.delete();
    endtask

    task automatic test_reset();
        sel8 = 0;
        do_reset();
    endtask

    task automatic test_basic();
        fwd_n = 0;
        push_str(0, "ab{\"k\":\"v\"}");
        load();
        run(100, 0, 0, 1);
        checks++;
        if (fwd_n != 9) begin errors++; $display("FAIL basic_len: forwarded %0d, want 9", fwd_n); end
    endtask

    task automatic test_rr_after_close();
        grants.delete();
        push_str(0, "{}"); push_str(1, "{}");
        load();
        run(100, 0, 0, 1);
        checks++;
        if (grants.size() != 2 || grants[0] != 1 || grants[1] != 0) begin
            errors++; $display("FAIL rr_after_close: %0d grants first=%0d, want 2 grants 1 then 0",
                               grants.size(), grants.size() > 0 ? grants[0] : -1);
        end
    endtask

    task automatic test_both_after_reset();
        do_reset();
        push_str(0, "{}{}"); push_str(1, "{}");
        load();
        run(100, 0, 0, 1);
        checks++;
        if (grants.size() != 3 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0) begin
            errors++; $display("FAIL rr_order: %0d grants, want 0,1,0", grants.size());
        end
    endtask

    task automatic test_string_brace();
        fwd_n = 0;
        push_str(1, "{\"a}b\":\"x\"}");
        load();
        run(100, 0, 0, 1);
        checks++;
        if (fwd_n != 11) begin errors++; $display("FAIL string_brace: forwarded %0d, want 11", fwd_n); end
    endtask

    task automatic test_backpressure();
        push_str(0, "{\"q\":1}x{ab}"); push_str(1, "z{\"}\"}");
        load();
        run(400, 1, 1, 1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            gen(0, 4); gen(1, 4);
            load();
            run(3000, 1, 1, 1);
        end
    endtask

    task automatic test_overrun();
        sel8 = 1;
        do_reset();
        push_str(0, "{abcdefghij");
        load();
        run(100, 0, 0, 1);
        checks++;
        if (er !== 1'b1 || cnt[0] !== 8'd0 || by !== 1'b0) begin
            errors++; $display("FAIL overrun: err=%b cnt0=%0d busy=%b, want 1 0 0", er, cnt[0], by);
        end
        push_str(0, "{abcdef}");
        load();
        run(100, 0, 0, 1);
        checks++;
        if (cnt[0] !== 8'd1 || er !== 1'b1) begin
            errors++; $display("FAIL close_at_max: cnt0=%0d err=%b, want 1 1", cnt[0], er);
        end
        sel8 = 0;
        do_reset();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 256; k++) push_str(0, "{}");
        load();
        run(1500, 0, 0, 1);
        checks++;
        if (cnt[0] !== 8'd0) begin errors++; $display("FAIL wrap: cnt0=%0d, want 0", cnt[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_str(0, "{abcdef}");
        load();
        run(3, 0, 0, 0);
        checks++;
        if (by !== 1'b1) begin errors++; $display("FAIL mid_busy: busy=%b, want 1", by); end
        do_reset();
        push_str(0, "{z}");
        load();
        run(100, 0, 0, 1);
    endtask

    initial begin
        v[0] = 0; v[1] = 0; c[0] = 0; c[1] = 0;
        test_reset();
        test_basic();
        test_rr_after_close();
        test_both_after_reset();
        test_string_brace();
        test_backpressure();
        test_random();
        test_overrun();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
